// File: rtl/uart_cmd_dispatcher.sv
// ----------------------------------------------------------------------------
// uart_cmd_dispatcher
//
// Purpose:
//   Decodes the DMA-fetched UART instruction word into {instr, code, data}
//   commands and queues each one in a per-channel FIFO. Every channel's FIFO
//   head is offered to its UART engine over a valid/ready handshake, so a
//   stalled engine only back-pressures commands addressed to its own channel.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   UART_ENB                   command valid (inputs sampled while high)
//   DMA_current_instruction    instruction word: ch=[28:27], op=[26:24],
//                              code=[16+CODE_W-1:16]
//   f_register_value           register operand for WRITE
//   immediate                  immediate operand for WRITEi
//   dec_ready                  dispatcher can accept the presented command
//   illegal                    one-cycle pulse after an illegal command is taken
//   ch_valid / ch_ready        per-channel head handshake
//   ch_instr / ch_code / ch_data  per-channel head fields, channel k packed at
//                              slice k (zero while the channel is empty)
//   ch_level                   per-channel occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module uart_cmd_dispatcher #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int CODE_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   UART_ENB,
    input  logic [31:0]                            DMA_current_instruction,
    input  logic [31:0]                            f_register_value,
    input  logic [23:0]                            immediate,
    output logic                                   dec_ready,
    output logic                                   illegal,
    output logic [NUM_CH-1:0]                      ch_valid,
    input  logic [NUM_CH-1:0]                      ch_ready,
    output logic [3*NUM_CH-1:0]                    ch_instr,
    output logic [CODE_W*NUM_CH-1:0]               ch_code,
    output logic [DATA_W*NUM_CH-1:0]               ch_data,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    ch_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 3 + CODE_W + DATA_W;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [2:0]       CH_LIMIT = 3'(NUM_CH);

    // Entry layout: {instr[2:0], code[CODE_W-1:0], data[DATA_W-1:0]}
    logic [ENT_W-1:0] mem_q     [NUM_CH][DEPTH];
    logic [ENT_W-1:0] mem_d     [NUM_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q  [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_d  [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_q  [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_d  [NUM_CH];
    logic [LVL_W-1:0] level_q   [NUM_CH];
    logic [LVL_W-1:0] level_d   [NUM_CH];
    logic             illegal_q;
    logic             illegal_d;

    logic [2:0]       op_s;
    logic [1:0]       ch_idx_s;
    logic             enq_raw_s;
    logic             bad_op_s;
    logic             bad_ch_s;
    logic             enq_s;
    logic             illegal_cmd_s;
    logic [ENT_W-1:0] ent_s;
    logic             target_full_s;
    logic             accept_s;
    logic             unused_inputs_s;

    assign op_s     = DMA_current_instruction[26:24];
    assign ch_idx_s = DMA_current_instruction[28:27];

    // Operand bits outside the decoded fields are intentionally ignored.
    assign unused_inputs_s = ^{DMA_current_instruction, f_register_value, immediate};

    // Opcode decode into the entry that would be queued.
    always_comb begin
        enq_raw_s = 1'b0;
        bad_op_s  = 1'b0;
        ent_s     = {ENT_W{1'b0}};
        case (op_s)
            3'b000: begin
                enq_raw_s = 1'b0;
            end
            3'b001: begin
                enq_raw_s = 1'b1;
                ent_s     = {3'b001, DMA_current_instruction[16 +: CODE_W], {DATA_W{1'b0}}};
            end
            3'b010: begin
                enq_raw_s = 1'b1;
                ent_s     = {3'b010, DMA_current_instruction[16 +: CODE_W], {DATA_W{1'b0}}};
            end
            3'b011: begin
                enq_raw_s = 1'b1;
                ent_s     = {3'b011, {CODE_W{1'b0}}, immediate[DATA_W-1:0]};
            end
            3'b100: begin
                // WRITE is queued with the same engine opcode as WRITEi.
                enq_raw_s = 1'b1;
                ent_s     = {3'b011, {CODE_W{1'b0}}, f_register_value[DATA_W-1:0]};
            end
            default: begin
                bad_op_s = 1'b1;
            end
        endcase
    end

    assign bad_ch_s      = ({1'b0, ch_idx_s} >= CH_LIMIT);
    assign illegal_cmd_s = bad_op_s | bad_ch_s;
    assign enq_s         = enq_raw_s & ~bad_ch_s;

    // Fullness of the addressed channel; only a legal enqueue can be stalled.
    always_comb begin
        target_full_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            target_full_s = target_full_s |
                            ((ch_idx_s == 2'(k)) && (level_q[k] == FULL_LVL));
        end
    end

    // Readiness looks only at the registered level, so a same-cycle pop on a
    // full channel never opens the input.
    assign dec_ready = ~(enq_s & target_full_s);
    assign accept_s  = UART_ENB & dec_ready;

    // Next-state for every channel FIFO plus the illegal pulse.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        illegal_d = accept_s & illegal_cmd_s;
        for (int k = 0; k < NUM_CH; k++) begin
            logic push_s;
            logic pop_s;
            push_s = accept_s & enq_s & (ch_idx_s == 2'(k));
            pop_s  = (level_q[k] != {LVL_W{1'b0}}) & ch_ready[k];
            if (push_s) begin
                mem_d[k][wr_ptr_q[k]] = ent_s;
                wr_ptr_d[k]           = wr_ptr_q[k] + PTR_W'(1);
            end else begin
                wr_ptr_d[k] = wr_ptr_q[k];
            end
            if (pop_s) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
            end else begin
                rd_ptr_d[k] = rd_ptr_q[k];
            end
            case ({push_s, pop_s})
                2'b10:   level_d[k] = level_q[k] + LVL_W'(1);
                2'b01:   level_d[k] = level_q[k] - LVL_W'(1);
                default: level_d[k] = level_q[k];
            endcase
        end
    end

    // State registers; reset wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[k][e] <= {ENT_W{1'b0}};
                end
                wr_ptr_q[k] <= {PTR_W{1'b0}};
                rd_ptr_q[k] <= {PTR_W{1'b0}};
                level_q[k]  <= {LVL_W{1'b0}};
            end
            illegal_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

    // Head presentation; fields are forced to zero while a channel is empty.
    always_comb begin
        ch_valid = {NUM_CH{1'b0}};
        ch_instr = {(3*NUM_CH){1'b0}};
        ch_code  = {(CODE_W*NUM_CH){1'b0}};
        ch_data  = {(DATA_W*NUM_CH){1'b0}};
        ch_level = {(NUM_CH*LVL_W){1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            ch_level[k*LVL_W +: LVL_W] = level_q[k];
            if (level_q[k] != {LVL_W{1'b0}}) begin
                ch_valid[k]                  = 1'b1;
                ch_instr[3*k +: 3]           = mem_q[k][rd_ptr_q[k]][ENT_W-1 -: 3];
                ch_code[CODE_W*k +: CODE_W]  = mem_q[k][rd_ptr_q[k]][DATA_W +: CODE_W];
                ch_data[DATA_W*k +: DATA_W]  = mem_q[k][rd_ptr_q[k]][DATA_W-1:0];
            end else begin
                ch_valid[k] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_dispatcher
//
// Directed, table-driven bench for uart_cmd_dispatcher (NUM_CH=2, DATA_W=8,
// CODE_W=8, DEPTH=4). Each table row gives the inputs for one cycle, the
// expected dec_ready before the edge and the expected outputs after it.
// A hand-written sequence then exercises push+pop across the pointer wrap.
// ----------------------------------------------------------------------------
module tb_uart_cmd_dispatcher;

    logic        clk;
    logic        reset;
    logic        UART_ENB;
    logic [31:0] DMA_current_instruction;
    logic [31:0] f_register_value;
    logic [23:0] immediate;
    logic        dec_ready;
    logic        illegal;
    logic [1:0]  ch_valid;
    logic [1:0]  ch_ready;
    logic [5:0]  ch_instr;
    logic [15:0] ch_code;
    logic [15:0] ch_data;
    logic [5:0]  ch_level;

    int checks;
    int failures;

    uart_cmd_dispatcher #(
        .NUM_CH (2),
        .DATA_W (8),
        .CODE_W (8),
        .DEPTH  (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .UART_ENB                (UART_ENB),
        .DMA_current_instruction (DMA_current_instruction),
        .f_register_value        (f_register_value),
        .immediate               (immediate),
        .dec_ready               (dec_ready),
        .illegal                 (illegal),
        .ch_valid                (ch_valid),
        .ch_ready                (ch_ready),
        .ch_instr                (ch_instr),
        .ch_code                 (ch_code),
        .ch_data                 (ch_data),
        .ch_level                (ch_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        enb;
        logic [31:0] ins;
        logic [31:0] freg;
        logic [23:0] imm;
        logic [1:0]  rdy;
        logic        dr;
        logic        ill;
        logic [1:0]  vld;
        logic [2:0]  l0;
        logic [2:0]  l1;
        logic [2:0]  i0;
        logic [7:0]  c0;
        logic [7:0]  d0;
        logic [2:0]  i1;
        logic [7:0]  c1;
        logic [7:0]  d1;
    } vec_t;

    vec_t vecs [26];

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [1:0] ch,
                                       input logic [7:0] code);
        mk = {3'b000, ch, op, code, 16'h0000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic enb, input logic [31:0] ins,
                         input logic [31:0] freg, input logic [23:0] imm,
                         input logic [1:0] rdy);
        reset                   = rst;
        UART_ENB                = enb;
        DMA_current_instruction = ins;
        f_register_value        = freg;
        immediate               = imm;
        ch_ready                = rdy;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        string t;
        t = $sformatf("v%0d", n);
        @(negedge clk);
        drive(v.rst, v.enb, v.ins, v.freg, v.imm, v.rdy);
        #1;
        chk({t, "_dec_ready"}, 32'(dec_ready), 32'(v.dr));
        @(posedge clk);
        #1;
        chk({t, "_illegal"}, 32'(illegal),       32'(v.ill));
        chk({t, "_valid"},   32'(ch_valid),      32'(v.vld));
        chk({t, "_level0"},  32'(ch_level[2:0]), 32'(v.l0));
        chk({t, "_level1"},  32'(ch_level[5:3]), 32'(v.l1));
        chk({t, "_instr0"},  32'(ch_instr[2:0]), 32'(v.i0));
        chk({t, "_code0"},   32'(ch_code[7:0]),  32'(v.c0));
        chk({t, "_data0"},   32'(ch_data[7:0]),  32'(v.d0));
        chk({t, "_instr1"},  32'(ch_instr[5:3]), 32'(v.i1));
        chk({t, "_code1"},   32'(ch_code[15:8]), 32'(v.c1));
        chk({t, "_data1"},   32'(ch_data[15:8]), 32'(v.d1));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          rst   enb   ins                      freg           imm          rdy     dr    ill   vld    l0    l1    i0    c0      d0      i1    c1      d1
        // single TELL on ch0, then drain
        vecs[0]  = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h5A), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b01, 3'd1, 3'd0, 3'd1, 8'h5A, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,                 32'h0, 24'h0, 2'b01, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};
        // ch1 WRITE then WRITEi with ready held high
        vecs[2]  = '{1'b0, 1'b1, mk(3'd4, 2'd1, 8'hFF), 32'h123456C3, 24'h0, 2'b10, 1'b1, 1'b0, 2'b10, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 3'd3, 8'h00, 8'hC3};
        vecs[3]  = '{1'b0, 1'b1, mk(3'd3, 2'd1, 8'hFF), 32'h0, 24'h00007E, 2'b10, 1'b1, 1'b0, 2'b10, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 3'd3, 8'h00, 8'h7E};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,                 32'h0, 24'h0, 2'b10, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};
        // fill ch0 to DEPTH, 5th stalls, ch1 still flows
        vecs[5]  = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h01), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b01, 3'd1, 3'd0, 3'd1, 8'h01, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h02), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b01, 3'd2, 3'd0, 3'd1, 8'h01, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h03), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b01, 3'd3, 3'd0, 3'd1, 8'h01, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h04), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b01, 3'd4, 3'd0, 3'd1, 8'h01, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h05), 32'h0, 24'h0, 2'b00, 1'b0, 1'b0, 2'b01, 3'd4, 3'd0, 3'd1, 8'h01, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 1'b1, mk(3'd1, 2'd1, 8'hB1), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b11, 3'd4, 3'd1, 3'd1, 8'h01, 8'h00, 3'd1, 8'hB1, 8'h00};
        // full + same-cycle pop: still not ready; accepted the cycle after
        vecs[11] = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h05), 32'h0, 24'h0, 2'b01, 1'b0, 1'b0, 2'b11, 3'd3, 3'd1, 3'd1, 8'h02, 8'h00, 3'd1, 8'hB1, 8'h00};
        vecs[12] = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h05), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b11, 3'd4, 3'd1, 3'd1, 8'h02, 8'h00, 3'd1, 8'hB1, 8'h00};
        vecs[13] = '{1'b0, 1'b0, 32'h0,                 32'h0, 24'h0, 2'b01, 1'b1, 1'b0, 2'b11, 3'd3, 3'd1, 3'd1, 8'h03, 8'h00, 3'd1, 8'hB1, 8'h00};
        vecs[14] = '{1'b0, 1'b0, 32'h0,                 32'h0, 24'h0, 2'b01, 1'b1, 1'b0, 2'b11, 3'd2, 3'd1, 3'd1, 8'h04, 8'h00, 3'd1, 8'hB1, 8'h00};
        vecs[15] = '{1'b0, 1'b0, 32'h0,                 32'h0, 24'h0, 2'b01, 1'b1, 1'b0, 2'b11, 3'd1, 3'd1, 3'd1, 8'h05, 8'h00, 3'd1, 8'hB1, 8'h00};
        vecs[16] = '{1'b0, 1'b0, 32'h0,                 32'h0, 24'h0, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};
        // illegal opcode, illegal channel, NOP
        vecs[17] = '{1'b0, 1'b1, mk(3'd6, 2'd0, 8'h00), 32'h0, 24'h0, 2'b00, 1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[18] = '{1'b0, 1'b0, 32'h0,                 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[19] = '{1'b0, 1'b1, mk(3'd1, 2'd3, 8'hAA), 32'h0, 24'h0, 2'b00, 1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[20] = '{1'b0, 1'b1, mk(3'd0, 2'd0, 8'h00), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};
        // fill to 3, then reset alongside a push and a pop
        vecs[21] = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h11), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b01, 3'd1, 3'd0, 3'd1, 8'h11, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[22] = '{1'b0, 1'b1, mk(3'd2, 2'd0, 8'h12), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b01, 3'd2, 3'd0, 3'd1, 8'h11, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[23] = '{1'b0, 1'b1, mk(3'd1, 2'd0, 8'h13), 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b01, 3'd3, 3'd0, 3'd1, 8'h11, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[24] = '{1'b1, 1'b1, mk(3'd1, 2'd0, 8'h14), 32'h0, 24'h0, 2'b01, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};
        vecs[25] = '{1'b0, 1'b0, 32'h0,                 32'h0, 24'h0, 2'b00, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00};

        // power-on reset
        drive(1'b1, 1'b0, 32'h0, 32'h0, 24'h0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   32'(ch_valid),  32'h0);
        chk("rst_level",   32'(ch_level),  32'h0);
        chk("rst_illegal", 32'(illegal),   32'h0);
        chk("rst_instr",   32'(ch_instr),  32'h0);
        chk("rst_code",    32'(ch_code),   32'h0);
        chk("rst_data",    32'(ch_data),   32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 24'h0, 2'b00);
        #1;
        chk("rst_dec_ready", 32'(dec_ready), 32'h1);

        for (int n = 0; n < 26; n++) begin
            run_vec(n, vecs[n]);
        end

        // push+pop at level 2 on ch0 across the pointer wrap
        @(negedge clk);
        drive(1'b0, 1'b1, mk(3'd1, 2'd0, 8'h20), 32'h0, 24'h0, 2'b00);
        @(negedge clk);
        drive(1'b0, 1'b1, mk(3'd1, 2'd0, 8'h21), 32'h0, 24'h0, 2'b00);
        @(posedge clk);
        #1;
        chk("wrap_prefill_level", 32'(ch_level[2:0]), 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, mk(3'd1, 2'd0, 8'(8'h22 + i)), 32'h0, 24'h0, 2'b01);
            #1;
            chk($sformatf("wrap%0d_dec_ready", i), 32'(dec_ready), 32'h1);
            chk($sformatf("wrap%0d_head_pre", i), 32'(ch_code[7:0]), 32'(8'h20 + i));
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_level", i), 32'(ch_level[2:0]), 32'd2);
            chk($sformatf("wrap%0d_head_post", i), 32'(ch_code[7:0]), 32'(8'h21 + i));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 24'h0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_dispatcher.md
Name: uart_cmd_dispatcher

Overview:
- Parametrised, registered successor to the combinational UART instruction decoder.
- Decodes the DMA-fetched UART instruction word into {instr, code, data} commands for NUM_CH UART channels; NUM_CH is no longer fixed at A/B.
- Each command is queued in a per-channel FIFO and presented to that channel's UART engine over a valid/ready handshake, so a slow channel stalls only its own traffic.
- Sits between the DMA/register-read stage and the UART channel engines.

Parameters:
- NUM_CH, 2, number of UART channels; legal range 1..4.
- DATA_W, 8, write-data width; legal range 1..24.
- CODE_W, 8, code-value width; legal range 1..8, taken from instr[16+CODE_W-1:16].
- DEPTH, 4, entries per channel FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- UART_ENB  in  1  command valid; instruction inputs are sampled when UART_ENB=1.
- DMA_current_instruction  in  32  instruction word.
- f_register_value  in  32  register operand for WRITE.
- immediate  in  24  immediate operand for WRITEi.
- dec_ready  out  1  dispatcher can accept the presented command.
- illegal  out  1  one-cycle pulse: the accepted command was illegal.
- ch_valid  out  NUM_CH  per channel: FIFO head is valid.
- ch_ready  in  NUM_CH  per channel: engine consumes the head.
- ch_instr  out  3*NUM_CH  head opcode; channel k at [3k+2:3k].
- ch_code  out  CODE_W*NUM_CH  head code value, packed the same way.
- ch_data  out  DATA_W*NUM_CH  head write data, packed the same way.
- ch_level  out  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy.

Behaviour:
Decode:
- op = instr[26:24]; channel index ch = instr[28:27].
- 000 NOP: not queued.
- 001 TELL: enqueue {001, code, 0}.
- 010 READ: enqueue {010, code, 0}.
- 011 WRITEi: enqueue {011, 0, immediate[DATA_W-1:0]}.
- 100 WRITE: enqueue {011, 0, f_register_value[DATA_W-1:0]}.
- 101..111, or ch >= NUM_CH: illegal. Accepted, not queued; illegal=1 in the following cycle only.

Accept handshake:
- dec_ready is combinational and is 1 unless the command decodes to an enqueue and FIFO[ch] is full.
- Accept = UART_ENB & dec_ready.
- When UART_ENB=1 and dec_ready=0, the upstream stage holds all inputs stable until acceptance.
- Enqueue is registered: an entry written at edge N drives ch_valid from after edge N. Empty-to-head latency is 1 cycle.

Output handshake:
- Pop on edge when ch_valid[k] & ch_ready[k].
- Head fields are stable while ch_valid[k]=1 and not popped.
- When ch_valid[k]=0, ch_instr/code/data for channel k read 0.
- ch_ready[k] with FIFO empty: ignored.

Boundary conditions:
- Push and pop on the same channel in one cycle: both happen, level unchanged. Allowed when the FIFO is non-full, or empty (the head goes valid next cycle).
- Full FIFO with a same-cycle pop: dec_ready stays 0 for that channel. No combinational ready-through.
- Channels are independent. A full channel k does not block a command to channel j≠k.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- UART_ENB=0: no state change except pops.

Reset:
- Synchronous. Takes priority over push and pop in the same cycle.
- Clears all pointers and levels: ch_valid=0, ch_level=0, all head fields 0, illegal=0.
- dec_ready becomes 1 in the cycle after reset is sampled.
- A mid-operation reset discards all queued commands.

Test Plan:
- Reset, then ATELL (op 001, ch 0, code 0x5A), ch_ready=0 -> next cycle ch_valid[0]=1, ch_instr[2:0]=001, ch_code[7:0]=0x5A, ch_level[0]=1; ch 1 idle.
- Ch 1: WRITE with f_register_value=0x1234_56C3, then WRITEi with immediate=0x0000_7E, ch_ready[1]=1 continuously -> heads 011/0xC3 then 011/0x7E on consecutive cycles, level never exceeds 1.
- Hold ch_ready[0]=0, issue 5 TELLs to ch 0 (DEPTH=4) -> 4 accepted, dec_ready=0 on the 5th; a BTELL to ch 1 in the next cycle is still accepted. Raise ch_ready[0] for one cycle -> 5th accepted the following cycle, FIFO order preserved.
- Op 110 and, with NUM_CH=2, ch=3 -> dec_ready=1, illegal pulses exactly 1 cycle each, no level changes. NOP -> no pulse, no enqueue.
- Fill ch 0 to 3 entries, assert reset for 1 cycle alongside a push and a pop -> all levels 0, ch_valid=0, dec_ready=1 next cycle.
- Simultaneous push and pop on ch 0 at level 2 for 10 cycles -> level stays 2, data order matches push order across the pointer wrap.
